rvc_compressor_packer: RTL and testbench
========================================

Name: rvc_compressor_packer

Overview:
- Write-side counterpart of the fetch decompressor: accepts a stream of 32-bit RV32I instructions and re-encodes each eligible one into its 16-bit RVC form.
- Packs the resulting 16/32-bit parcels little-endian into 32-bit memory words (first parcel in bits [15:0]).
- Sits between the program loader/test-image generator and instruction-memory write port; its output words must decompress back to the original instructions.
- Does not relocate branch/jump offsets; upstream marks each instruction compressible via in_compress_ok and owns the layout.

Parameters:
- ENABLE_RVC, 1, 0 = never compress (pure pass-through packer).
- STAT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_instr  in  32  RV32I instruction
- in_compress_ok  in  1  compression permitted for this instruction
- flush  in  1  request: pad residue and drain; held until flush_done
- flush_done  out  1  one-cycle pulse, flush completed
- out_valid  out  1  out_word valid
- out_ready  in  1  consumer accepts out_word
- out_word  out  32  packed memory word
- stat_total  out  STAT_WIDTH  instructions accepted (saturating)
- stat_compressed  out  STAT_WIDTH  instructions emitted as 16-bit (saturating)

Behaviour:
- Reset: out_valid=0, out_word=0, flush_done=0, state=EMPTY, residue=0, stats=0. Reset mid-operation drops residue and pending word.
- Compression is combinational on in_instr and is used only if ENABLE_RVC && in_compress_ok. Rules:
  - C.ADDI: addi rd,rd,imm; rd≠0, imm≠0, -32≤imm≤31.
  - C.LI: addi rd,x0,imm; rd≠0, -32≤imm≤31.
  - C.LUI: not compressed.
  - C.SLLI: rd=rs1≠0, shamt 1..31.
  - C.SRLI/C.SRAI/C.ANDI: rd=rs1∈x8–x15; shamt 1..31; andi imm -32..31.
  - C.SUB/C.XOR/C.OR/C.AND: rd=rs1∈x8–x15, rs2∈x8–x15.
  - C.MV: add rd,x0,rs2; rd,rs2≠0.
  - C.ADD: add rd,rd,rs2; rd,rs2≠0.
  - C.LW/C.SW: rs1', rd'/rs2' ∈x8–x15; offset multiple of 4, 0..124.
  - C.J/C.JAL: jal x0/x1, offset even, -2048..2046.
  - C.JR/C.JALR: jalr x0/x1,0(rs1), rs1≠0.
  - C.BEQZ/C.BNEZ: rs2=x0, rs1∈x8–x15, offset even, -256..254.
  - Everything else stays 32-bit.
- Packer states:
  - EMPTY + 32-bit parcel: out_word=instr.
  - EMPTY + 16-bit parcel: residue=c, go HALF, no output.
  - HALF + 16-bit parcel: out_word={c,residue}, go EMPTY.
  - HALF + 32-bit parcel: out_word={instr[15:0],residue}, residue=instr[31:16], stay HALF.
- Output register: one entry. out_word/out_valid are registered, so there is 1 cycle from acceptance to out_valid. out_word holds stable while out_valid && !out_ready.
- in_ready = !out_valid || out_ready. This is combinational, gives full throughput, and means no word is ever dropped.
- Flush:
  - Acts only in a cycle with in_valid=0 and in_ready=1. If in_valid=1, the instruction has priority and flush waits.
  - HALF: emit {16'h0001 (C.NOP), residue}, go EMPTY, flush_done next cycle with out_valid.
  - EMPTY: flush_done next cycle, no output.
  - Flush held after flush_done restarts a new flush (no-op in EMPTY).
- Stats increment on acceptance; saturate at all-ones.

Test Plan:
- Two addi x8,x8,1 (0x00140413), in_compress_ok=1 -> out_word=0x04050405 one cycle after second accept; stat_compressed=2.
- addi x8,x8,1 then lui x5,0x12345 (0x123452B7), then flush -> 0x52B70405, then 0x00011234 with flush_done pulse; state EMPTY.
- Boundaries from EMPTY:
  - addi x8,x8,32 (0x02040413) -> passes unchanged as out_word=0x02040413.
  - addi x8,x8,-32, addi x8,x8,-32 -> 0x14011401.
- lw x9,4(x10) (0x00452483) twice -> 0x41444144; same with in_compress_ok=0 -> 0x00452483 twice.
- out_ready=0 for 5 cycles with words pending -> in_ready=0 after first word, out_word stable, no loss; release -> words in order.
- HALF with residue, assert rst one cycle -> out_valid=0, stats=0, then flush gives flush_done with no output.

Source files
------------

// File: rtl/rvc_compressor_packer.sv
// Purpose : re-encode eligible RV32I instructions as RVC and pack 16/32-bit parcels little-endian into 32-bit words.
// Latency : 1 cycle from the accept of the instruction that completes a word to out_valid; a lone half-word waits in residue.
// Backpr. : in_ready = !out_valid || out_ready; the single output register holds out_word stable while stalled.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready/in_instr  instruction stream; in_compress_ok permits RVC re-encoding of this instruction
//   flush/flush_done            pad a pending half-word with C.NOP and drain; flush_done pulses once per flush
//   out_valid/out_ready/out_word  packed memory words
//   stat_total/stat_compressed  saturating counters of accepted / 16-bit-emitted instructions
module rvc_compressor_packer #(
    parameter bit ENABLE_RVC = 1'b1,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic                  in_compress_ok,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_word,
    output logic [STAT_WIDTH-1:0] stat_total,
    output logic [STAT_WIDTH-1:0] stat_compressed
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm_i, imm_s;
    logic [12:1] imm_b;
    logic [20:1] imm_j;
    logic        imm6_ok, rd_p, rs1_p, rs2_p;

    assign opc   = in_instr[6:0];
    assign rd    = in_instr[11:7];
    assign f3    = in_instr[14:12];
    assign rs1   = in_instr[19:15];
    assign rs2   = in_instr[24:20];
    assign f7    = in_instr[31:25];
    assign imm_i = in_instr[31:20];
    assign imm_s = {in_instr[31:25], in_instr[11:7]};
    assign imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
    assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};

    // 12-bit immediate representable as a signed 6-bit value (-32..31)
    assign imm6_ok = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7F);
    // x8..x15 are the only registers reachable by the 3-bit RVC fields
    assign rd_p  = (rd[4:3]  == 2'b01);
    assign rs1_p = (rs1[4:3] == 2'b01);
    assign rs2_p = (rs2[4:3] == 2'b01);

    // ------------------------------------------------------------------
    // Combinational compressor
    // ------------------------------------------------------------------
    logic        c_hit;
    logic [15:0] c_instr;
    logic [1:0]  c_alu_op;

    always_comb begin
        c_hit    = 1'b0;
        c_instr  = 16'h0000;
        c_alu_op = 2'b00;
        case (opc)
            OPC_OP_IMM: begin
                case (f3)
                    3'b000: begin
                        if (rd != 5'd0 && imm6_ok) begin
                            if (rs1 == 5'd0) begin
                                c_hit   = 1'b1;
                                c_instr = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                            end else if (rs1 == rd && imm_i != 12'd0) begin
                                c_hit   = 1'b1;
                                c_instr = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                            end
                        end
                    end
                    3'b001: begin
                        if (f7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                            c_hit   = 1'b1;
                            c_instr = {3'b000, 1'b0, rd, rs2, 2'b10};
                        end
                    end
                    3'b101: begin
                        if (rd == rs1 && rd_p && rs2 != 5'd0) begin
                            if (f7 == 7'b0000000) begin
                                c_hit   = 1'b1;
                                c_instr = {3'b100, 1'b0, 2'b00, rd[2:0], rs2, 2'b01};
                            end else if (f7 == 7'b0100000) begin
                                c_hit   = 1'b1;
                                c_instr = {3'b100, 1'b0, 2'b01, rd[2:0], rs2, 2'b01};
                            end
                        end
                    end
                    3'b111: begin
                        if (rd == rs1 && rd_p && imm6_ok) begin
                            c_hit   = 1'b1;
                            c_instr = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
                        end
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                if (f7 == 7'd0 && f3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0) begin
                    if (rs1 == 5'd0) begin
                        c_hit   = 1'b1;
                        c_instr = {4'b1000, rd, rs2, 2'b10};
                    end else if (rs1 == rd) begin
                        c_hit   = 1'b1;
                        c_instr = {4'b1001, rd, rs2, 2'b10};
                    end
                end else if (rd == rs1 && rd_p && rs2_p) begin
                    if (f7 == 7'b0100000 && f3 == 3'b000) begin
                        c_hit    = 1'b1;
                        c_alu_op = 2'b00;
                    end else if (f7 == 7'd0 && f3 == 3'b100) begin
                        c_hit    = 1'b1;
                        c_alu_op = 2'b01;
                    end else if (f7 == 7'd0 && f3 == 3'b110) begin
                        c_hit    = 1'b1;
                        c_alu_op = 2'b10;
                    end else if (f7 == 7'd0 && f3 == 3'b111) begin
                        c_hit    = 1'b1;
                        c_alu_op = 2'b11;
                    end
                    c_instr = {3'b100, 1'b0, 2'b11, rd[2:0], c_alu_op, rs2[2:0], 2'b01};
                end
            end
            OPC_LOAD: begin
                if (f3 == 3'b010 && rd_p && rs1_p && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0) begin
                    c_hit   = 1'b1;
                    c_instr = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
                end
            end
            OPC_STORE: begin
                if (f3 == 3'b010 && rs1_p && rs2_p && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0) begin
                    c_hit   = 1'b1;
                    c_instr = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
                end
            end
            OPC_JAL: begin
                // offset must sign-extend from bit 11 (-2048..2046)
                if (rd[4:1] == 4'd0 && (imm_j[20:11] == 10'h000 || imm_j[20:11] == 10'h3FF)) begin
                    c_hit   = 1'b1;
                    c_instr = {rd[0] ? 3'b001 : 3'b101, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10],
                               imm_j[6], imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
                end
            end
            OPC_JALR: begin
                if (f3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 && rd[4:1] == 4'd0) begin
                    c_hit   = 1'b1;
                    c_instr = {3'b100, rd[0], rs1, 5'd0, 2'b10};
                end
            end
            OPC_BRANCH: begin
                // offset must sign-extend from bit 8 (-256..254)
                if (f3[2:1] == 2'b00 && rs2 == 5'd0 && rs1_p &&
                    (imm_b[12:8] == 5'h00 || imm_b[12:8] == 5'h1F)) begin
                    c_hit   = 1'b1;
                    c_instr = {2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6],
                               imm_b[2:1], imm_b[5], 2'b01};
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Packer
    // ------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [15:0]             residue_q, residue_d;
    logic                    out_valid_q, out_valid_d;
    logic [31:0]             out_word_q, out_word_d;
    logic                    flush_done_q, flush_done_d;
    logic [STAT_WIDTH-1:0]   stat_total_q, stat_total_d;
    logic [STAT_WIDTH-1:0]   stat_comp_q, stat_comp_d;
    logic                    use_c, accept, flush_act;

    assign in_ready  = !out_valid_q || out_ready;
    assign use_c     = ENABLE_RVC && in_compress_ok && c_hit;
    assign accept    = in_valid && in_ready;
    // an offered instruction always wins over a pending flush
    assign flush_act = flush && !in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        residue_d    = residue_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_word_d   = out_word_q;
        flush_done_d = 1'b0;
        stat_total_d = stat_total_q;
        stat_comp_d  = stat_comp_q;

        if (accept) begin
            if (stat_total_q != STAT_MAX) begin
                stat_total_d = stat_total_q + STAT_ONE;
            end
            if (use_c && stat_comp_q != STAT_MAX) begin
                stat_comp_d = stat_comp_q + STAT_ONE;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (use_c) begin
                        residue_d = c_instr;
                        state_d   = ST_HALF;
                    end else begin
                        out_valid_d = 1'b1;
                        out_word_d  = in_instr;
                    end
                end
                default: begin
                    out_valid_d = 1'b1;
                    if (use_c) begin
                        out_word_d = {c_instr, residue_q};
                        residue_d  = 16'h0000;
                        state_d    = ST_EMPTY;
                    end else begin
                        // 32-bit parcel straddles the word boundary
                        out_word_d = {in_instr[15:0], residue_q};
                        residue_d  = in_instr[31:16];
                    end
                end
            endcase
        end else if (flush_act) begin
            flush_done_d = 1'b1;
            if (state_q == ST_HALF) begin
                out_valid_d = 1'b1;
                out_word_d  = {16'h0001, residue_q};
                residue_d   = 16'h0000;
                state_d     = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            residue_q    <= 16'h0000;
            out_valid_q  <= 1'b0;
            out_word_q   <= 32'h0000_0000;
            flush_done_q <= 1'b0;
            stat_total_q <= '0;
            stat_comp_q  <= '0;
        end else begin
            state_q      <= state_d;
            residue_q    <= residue_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            flush_done_q <= flush_done_d;
            stat_total_q <= stat_total_d;
            stat_comp_q  <= stat_comp_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_word        = out_word_q;
    assign flush_done      = flush_done_q;
    assign stat_total      = stat_total_q;
    assign stat_compressed = stat_comp_q;

endmodule

// File: tb/tb_rvc_compressor_packer.sv
// Purpose : directed and random checking of rvc_compressor_packer against an instruction-level model.
// Latency : model tracks a half-word queue; words are expected in order whenever two half-words exist.
// Backpr. : random out_ready stalls; words are compared when handshaken.
module tb_rvc_compressor_packer;

    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic          in_compress_ok;
    logic          flush;
    logic          flush_done;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_word;
    logic [SW-1:0] stat_total;
    logic [SW-1:0] stat_compressed;

    rvc_compressor_packer #(.ENABLE_RVC(1'b1), .STAT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_compress_ok(in_compress_ok),
        .flush(flush), .flush_done(flush_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .stat_total(stat_total), .stat_compressed(stat_compressed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] hq[$];
    logic [31:0] exp_q[$];
    int          n_total = 0;
    int          n_comp = 0;
    bit          fd_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit creg(input int r);
        return r >= 8 && r <= 15;
    endfunction

    // Reference compressor: rules evaluated on decoded fields with signed integer ranges.
    function automatic bit mcomp(input logic [31:0] x, output logic [15:0] c);
        int opc, rd, rs1, rs2, f3, f7, ii, is, ib, ij;
        logic [31:0] v;
        logic [2:0] rdp, rs1p, rs2p;
        opc = int'(x[6:0]);  rd = int'(x[11:7]);  f3 = int'(x[14:12]);
        rs1 = int'(x[19:15]); rs2 = int'(x[24:20]); f7 = int'(x[31:25]);
        ii = int'($signed(x[31:20]));
        is = int'($signed({x[31:25], x[11:7]}));
        ib = int'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
        ij = int'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
        rdp = 3'(rd - 8); rs1p = 3'(rs1 - 8); rs2p = 3'(rs2 - 8);
        c = 16'h0;
        if (opc == 'h13 && f3 == 0 && rd != 0 && rs1 == 0 && ii >= -32 && ii <= 31) begin
            v = ii; c = {3'b010, v[5], x[11:7], v[4:0], 2'b01}; return 1;
        end
        if (opc == 'h13 && f3 == 0 && rd != 0 && rs1 == rd && ii != 0 && ii >= -32 && ii <= 31) begin
            v = ii; c = {3'b000, v[5], x[11:7], v[4:0], 2'b01}; return 1;
        end
        if (opc == 'h13 && f3 == 1 && f7 == 0 && rd != 0 && rd == rs1 && rs2 >= 1) begin
            c = {4'b0000, x[11:7], x[24:20], 2'b10}; return 1;
        end
        if (opc == 'h13 && f3 == 5 && (f7 == 0 || f7 == 'h20) && rd == rs1 && creg(rd) && rs2 >= 1) begin
            c = {4'b1000, (f7 == 'h20) ? 2'b01 : 2'b00, rdp, x[24:20], 2'b01}; return 1;
        end
        if (opc == 'h13 && f3 == 7 && rd == rs1 && creg(rd) && ii >= -32 && ii <= 31) begin
            v = ii; c = {3'b100, v[5], 2'b10, rdp, v[4:0], 2'b01}; return 1;
        end
        if (opc == 'h33 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && rs1 == 0) begin
            c = {4'b1000, x[11:7], x[24:20], 2'b10}; return 1;
        end
        if (opc == 'h33 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && rs1 == rd) begin
            c = {4'b1001, x[11:7], x[24:20], 2'b10}; return 1;
        end
        if (opc == 'h33 && rd == rs1 && creg(rd) && creg(rs2)) begin
            logic [1:0] op;
            bit hit;
            hit = 1;
            if (f7 == 'h20 && f3 == 0) op = 2'd0;
            else if (f7 == 0 && f3 == 4) op = 2'd1;
            else if (f7 == 0 && f3 == 6) op = 2'd2;
            else if (f7 == 0 && f3 == 7) op = 2'd3;
            else begin op = 2'd0; hit = 0; end
            if (hit) begin c = {6'b100011, rdp, op, rs2p, 2'b01}; return 1; end
        end
        if (opc == 'h03 && f3 == 2 && creg(rd) && creg(rs1) && ii % 4 == 0 && ii >= 0 && ii <= 124) begin
            v = ii; c = {3'b010, v[5:3], rs1p, v[2], v[6], rdp, 2'b00}; return 1;
        end
        if (opc == 'h23 && f3 == 2 && creg(rs2) && creg(rs1) && is % 4 == 0 && is >= 0 && is <= 124) begin
            v = is; c = {3'b110, v[5:3], rs1p, v[2], v[6], rs2p, 2'b00}; return 1;
        end
        if (opc == 'h6F && (rd == 0 || rd == 1) && ij >= -2048 && ij <= 2046) begin
            v = ij;
            c = {(rd == 1) ? 3'b001 : 3'b101, v[11], v[4], v[9:8], v[10], v[6], v[7], v[3:1], v[5], 2'b01};
            return 1;
        end
        if (opc == 'h67 && f3 == 0 && ii == 0 && rs1 != 0 && (rd == 0 || rd == 1)) begin
            c = {3'b100, (rd == 1), x[19:15], 5'd0, 2'b10}; return 1;
        end
        if (opc == 'h63 && (f3 == 0 || f3 == 1) && rs2 == 0 && creg(rs1) && ib >= -256 && ib <= 254) begin
            v = ib; c = {2'b11, (f3 == 1), v[8], v[4:3], rs1p, v[7:6], v[2:1], v[5], 2'b01}; return 1;
        end
        return 0;
    endfunction

    function automatic void pack_words();
        while (hq.size() >= 2) begin
            logic [15:0] lo, hi;
            lo = hq.pop_front();
            hi = hq.pop_front();
            exp_q.push_back({hi, lo});
        end
    endfunction

    function automatic void model_accept(input logic [31:0] x, input bit ok);
        logic [15:0] c;
        bit is_c;
        is_c = mcomp(x, c) && ok;
        n_total++;
        if (is_c) begin
            n_comp++;
            hq.push_back(c);
        end else begin
            hq.push_back(x[15:0]);
            hq.push_back(x[31:16]);
        end
        pack_words();
    endfunction

    function automatic int sat(input int n);
        return (n > (1 << SW) - 1) ? (1 << SW) - 1 : n;
    endfunction

    // One clock: check at the falling edge, advance the model after the rising edge.
    task automatic cycle(output bit acc);
        bit fire, fl, r;
        @(negedge clk);
        r    = rst;
        fire = out_valid && out_ready;
        acc  = in_valid && in_ready && !r;
        fl   = flush && !in_valid && in_ready && !r;
        chk("flush_done", flush_done, fd_exp);
        chk("stat_total", stat_total, sat(n_total));
        chk("stat_compressed", stat_compressed, sat(n_comp));
        if (fire && !r) begin
            chk("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("out_word", out_word, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (r) begin
            hq.delete(); exp_q.delete();
            n_total = 0; n_comp = 0; fd_exp = 0;
        end else begin
            fd_exp = fl;
            if (acc) model_accept(in_instr, in_compress_ok);
            if (fl && hq.size() == 1) begin
                hq.push_back(16'h0001);
                pack_words();
            end
        end
    endtask

    task automatic idle();
        bit a;
        cycle(a);
    endtask

    task automatic send(input logic [31:0] x, input bit ok);
        bit a;
        a = 0;
        in_valid = 1'b1; in_instr = x; in_compress_ok = ok;
        for (int i = 0; i < 50; i++) begin
            cycle(a);
            if (a) break;
        end
        if (!a) chk("send_timeout", a, 1);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd, input logic [31:0] opc);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd, input logic [31:0] opc);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2, input logic [31:0] rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    function automatic int rreg();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 31);
            1: return $urandom_range(0, 2);
            default: return $urandom_range(8, 15);
        endcase
    endfunction

    function automatic int pick(input int a, input int b, input int c, input int d, input int rnd);
        case ($urandom_range(0, 4))
            0: return a;
            1: return b;
            2: return c;
            3: return d;
            default: return rnd;
        endcase
    endfunction

    function automatic logic [31:0] gen();
        int rd, rs1, rs2, k;
        rd = rreg(); rs2 = rreg();
        rs1 = ($urandom_range(0, 2) == 0) ? rreg() : rd;
        k = $urandom_range(0, 9);
        case (k)
            0: return enc_i(pick(-33, -32, 31, 32, $urandom_range(0, 4095) - 2048),
                            ($urandom_range(0, 3) == 0) ? 0 : rs1, 0, rd, 'h13);
            1: return enc_r(($urandom_range(0, 1) == 0) ? 0 : 'h20, $urandom_range(0, 31), rs1,
                            ($urandom_range(0, 1) == 0) ? 1 : 5, rd, 'h13);
            2: return enc_i(pick(-32, 31, 32, 0, $urandom_range(0, 4095)), rs1, 7, rd, 'h13);
            3: return enc_r(($urandom_range(0, 2) == 0) ? 'h20 : 0, rs2,
                            ($urandom_range(0, 2) == 0) ? 0 : rs1, pick(0, 4, 6, 7, $urandom_range(0, 7)), rd, 'h33);
            4: return enc_i(pick(0, 124, 128, 2, $urandom_range(0, 31) * 4), rs1, 2, rd, 'h03);
            5: return enc_s(pick(0, 124, 128, -4, $urandom_range(0, 31) * 4), rs2, rs1);
            6: return enc_j(pick(-2048, 2046, 2048, -2050, ($urandom_range(0, 8191) - 4096) * 2),
                            ($urandom_range(0, 3) == 0) ? rreg() : $urandom_range(0, 1));
            7: return enc_i(($urandom_range(0, 3) == 0) ? 4 : 0, rs1, 0, $urandom_range(0, 2), 'h67);
            8: return enc_b(pick(-256, 254, 256, -258, ($urandom_range(0, 511) - 256) * 2),
                            ($urandom_range(0, 3) == 0) ? rs2 : 0, rs1, $urandom_range(0, 2));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        bit a;
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_compress_ok = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        idle(); idle();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_stat_total", stat_total, 0);
        chk("rst_in_ready", in_ready, 1);

        // two C.ADDI pack into one word
        send(32'h00140413, 1);
        chk("half_no_output", out_valid, 0);
        send(32'h00140413, 1);
        chk("pair_valid", out_valid, 1);
        chk("pair_word", out_word, 32'h04050405);
        chk("pair_stat_comp", stat_compressed, 2);
        idle();

        // straddling 32-bit parcel, then flush pads with C.NOP
        send(32'h00140413, 1);
        send(32'h123452B7, 1);
        chk("straddle_word", out_word, 32'h52B70405);
        flush = 1'b1;
        idle();
        flush = 1'b0;
        chk("flush_done_pulse", flush_done, 1);
        chk("flush_valid", out_valid, 1);
        chk("flush_word", out_word, 32'h00011234);

        // immediate boundaries from EMPTY
        send(32'h02040413, 1);
        chk("addi32_passthru", out_word, 32'h02040413);
        send(enc_i(-32, 8, 0, 8, 'h13), 1);
        send(enc_i(-32, 8, 0, 8, 'h13), 1);
        chk("addi_m32_pair", out_word, 32'h14011401);

        // C.LW with and without permission
        send(32'h00452483, 1);
        send(32'h00452483, 1);
        chk("clw_pair", out_word, 32'h41444144);
        send(32'h00452483, 0);
        chk("lw_noperm_1", out_word, 32'h00452483);
        send(32'h00452483, 0);
        chk("lw_noperm_2", out_word, 32'h00452483);
        idle();

        // consumer stall: one word held, input blocked, nothing lost
        out_ready = 1'b0;
        send(32'h123452B7, 1);
        chk("stall_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        in_valid = 1'b1; in_instr = 32'h00452483; in_compress_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(a);
            chk("stall_word_stable", out_word, 32'h123452B7);
            chk("stall_blocked", in_ready, 0);
        end
        out_ready = 1'b1;
        send(32'h00452483, 0);
        chk("stall_next_word", out_word, 32'h00452483);
        idle();

        // reset with residue and a pending word
        send(32'h00140413, 1);
        out_ready = 1'b0;
        send(32'h123452B7, 1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_word", out_word, 32'h0);
        chk("mid_rst_stat_total", stat_total, 0);
        chk("mid_rst_stat_comp", stat_compressed, 0);
        out_ready = 1'b1;
        flush = 1'b1;
        idle();
        flush = 1'b0;
        chk("empty_flush_done", flush_done, 1);
        chk("empty_flush_no_word", out_valid, 0);

        // random traffic; stats saturate at 8 bits
        for (int i = 0; i < 3000; i++) begin
            in_valid       = ($urandom_range(0, 9) < 7);
            in_instr       = gen();
            in_compress_ok = ($urandom_range(0, 9) < 8);
            out_ready      = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 19) == 0);
            cycle(a);
        end

        // drain
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        idle();
        flush = 1'b0;
        for (int i = 0; i < 10; i++) idle();
        chk("drain_words_left", exp_q.size(), 0);
        chk("drain_halves_left", hq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
